fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor of the ID-stage forwarding unit. Tracks in-flight register writes internally, over a configurable number of pipeline stages, instead of taking per-stage address/enable inputs.
- Forwards the youngest ready result to NUM_RD ID read ports.
- Raises a stall when the youngest matching producer's result is not yet available, e.g. load-use or multi-cycle ops.
- Sits between the ID stage, the register file and the EXE..WB result buses.

Parameters:
- DW, 32, data width.
- AW, 5, register address width.
- NUM_RD, 3, number of ID read ports (rs1, rs2, store-data).
- DEPTH, 3, tracked stages after ID (1 = EXE ... DEPTH = last stage before the register file write).
- LW, 2, width of latency field, clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rd_en  in  NUM_RD  per-port read enable.
- id_rd_addr  in  NUM_RD*AW  per-port source address, port i at [i*AW +: AW].
- id_rd_data  in  NUM_RD*DW  register file read data per port.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_addr  in  AW  destination address.
- id_wr_lat  in  LW  first stage (1..DEPTH) whose stage_data holds the result; 1 = ALU, 2 = load.
- stage_data  in  DEPTH*DW  result bus of stage s at [(s-1)*DW +: DW].
- flush  in  1  kill all in-flight tracking (branch/exception).
- stall_o  out  1  hold ID/IF and inject a bubble into EXE.
- fwd_data  out  NUM_RD*DW  operand per port.
- fwd_hit  out  NUM_RD  port was served from a pipeline stage.

Behaviour:
- State per stage s: v[s], addr[s], lat[s].
- Reset, asynchronous and active-low: all v = 0; addr and lat = 0. Outputs then read stall_o = 0, fwd_hit = 0, fwd_data = id_rd_data.
- Ready condition: stage s is ready iff s >= lat[s].
- Match, per port i:
  - stage s matches iff id_rd_en[i] && v[s] && addr[s] == id_rd_addr[i].
  - The youngest (lowest s) match wins; older matches are ignored even if ready.
- Forward, per port i:
  - If the winner is ready: fwd_data = stage_data of that stage, fwd_hit = 1.
  - If no match: fwd_data = id_rd_data, fwd_hit = 0.
  - If the winner is not ready: fwd_data = id_rd_data, fwd_hit = 0, and the port requests a stall.
- Stall: stall_o = id_valid && OR of all per-port stall requests. Purely combinational, zero latency.
- Shift, at each clock edge, priority order:
  1. flush = 1: all v <= 0 (flush beats stall and insertion).
  2. Otherwise stages s = 2..DEPTH take stage s-1; stage DEPTH's old entry retires.
  3. Stage 1 load when stall_o = 1: bubble (v = 0).
  4. Stage 1 load when stall_o = 0: v <= id_valid && id_wr_en; addr <= id_wr_addr; lat <= id_wr_lat.
- A stalled producer advances one stage per cycle; stall releases automatically once it reaches its lat stage. Single-cycle load-use gives exactly 1 stall cycle.
- The register file must be write-through for the retiring write. Results retiring past DEPTH are visible via id_rd_data in the same cycle.
- id_wr_lat = 0 is treated as 1. id_wr_lat > DEPTH is illegal; the bench asserts it never occurs.
- Address 0 is forwarded like any other register.
- Same address in multiple stages: the youngest wins (WAW correct).
- Mid-operation reset clears tracking immediately, asynchronously; stall_o drops in the same cycle.

Optional Feature:
- Macro FWD_STALL_STATS_EN.
- When defined: adds output stall_cnt [31:0], a count of cycles with stall_o = 1.
  - Saturates at 0xFFFF_FFFF.
  - Cleared by rst only; flush does not clear it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: DW/AW defaults and the stage-entry struct {v, addr, lat}.
- Shared package: the latency encodings LAT_ALU = 1 and LAT_LOAD = 2, replacing the MvRegSrc/DM-read mux select of the older unit.
- One sub-module, fwd_port_sel: per-port youngest-match priority select, instantiated NUM_RD times via generate.

Test Plan:
- ALU chain: I1 writes r3 (lat 1, EXE result 0x11); next cycle port0 reads r3 -> fwd_hit[0] = 1, fwd_data = 0x11, stall_o = 0.
- Load-use: load writes r5 (lat 2); next cycle port1 reads r5 -> stall_o = 1 for exactly 1 cycle. Then stage 2 data 0xABCD is forwarded with fwd_hit[1] = 1.
- WAW priority: r7 in stage 2 = 0x2 and stage 1 = 0x1, both ready -> fwd_data = 0x1.
- Flush during stall: load-use stall asserted, flush = 1 -> next cycle all v = 0, stall_o = 0, fwd_data = id_rd_data.
- Retire boundary: producer reaches DEPTH+1 -> fwd_hit = 0, value taken from id_rd_data (write-through), no stall.
- Reset mid-stall: rst low while stall_o = 1 -> stall_o = 0 immediately; with FWD_STALL_STATS_EN, stall_cnt = 0.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard: default widths,
// the per-stage tracking entry and the producer latency encodings.
package fwd_scoreboard_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int LW_DEF = 2;

    // First stage whose result bus carries the value (replaces the old mux select)
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    typedef struct packed {
        logic              v;
        logic [AW_DEF-1:0] addr;
        logic [LW_DEF-1:0] lat;
    } stage_entry_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port youngest-match select: picks the lowest matching stage and
// either forwards its result or, if it is not ready yet, requests a stall.
module fwd_port_sel
    import fwd_scoreboard_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 3
) (
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    input  logic [DW-1:0]       rd_data,
    input  logic [DEPTH-1:0]    stage_v,
    input  logic [DEPTH*AW-1:0] stage_addr,
    input  logic [DEPTH-1:0]    stage_rdy,
    input  logic [DEPTH*DW-1:0] stage_data,
    output logic [DW-1:0]       fwd_data,
    output logic                fwd_hit,
    output logic                stall_req
);

    logic          win_found;
    logic          win_rdy;
    logic [DW-1:0] win_data;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        win_found = 1'b0;
        win_rdy   = 1'b0;
        win_data  = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (rd_en && stage_v[s] && (stage_addr[s*AW +: AW] == rd_addr)) begin
                win_found = 1'b1;
                win_rdy   = stage_rdy[s];
                win_data  = stage_data[s*DW +: DW];
            end
        end
    end

    always_comb begin
        fwd_hit   = win_found && win_rdy;
        stall_req = win_found && !win_rdy;
        fwd_data  = fwd_hit ? win_data : rd_data;
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// ID-stage forwarding scoreboard: tracks in-flight register writes over DEPTH
// stages, forwards the youngest ready result per read port and stalls ID when
// the youngest producer is not ready. AW/LW must not exceed the package widths.
// Optional FWD_STALL_STATS_EN adds a saturating stall-cycle counter output.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int NUM_RD = 3,
    parameter int DEPTH  = 3,
    parameter int LW     = LW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NUM_RD-1:0]    id_rd_en,
    input  logic [NUM_RD*AW-1:0] id_rd_addr,
    input  logic [NUM_RD*DW-1:0] id_rd_data,
    input  logic                 id_wr_en,
    input  logic [AW-1:0]        id_wr_addr,
    input  logic [LW-1:0]        id_wr_lat,
    input  logic [DEPTH*DW-1:0]  stage_data,
    input  logic                 flush,
    output logic                 stall_o,
    output logic [NUM_RD*DW-1:0] fwd_data,
`ifdef FWD_STALL_STATS_EN
    output logic [NUM_RD-1:0]    fwd_hit,
    output logic [31:0]          stall_cnt
`else
    output logic [NUM_RD-1:0]    fwd_hit
`endif
);

    stage_entry_t stage_q [DEPTH];
    stage_entry_t stage_d [DEPTH];

    logic [DEPTH-1:0]    stage_v;
    logic [DEPTH*AW-1:0] stage_addr;
    logic [DEPTH-1:0]    stage_rdy;
    logic [NUM_RD-1:0]   port_stall;
    logic [LW-1:0]       wr_lat_eff;

    // A stage is ready once the entry has reached its result stage.
    always_comb begin
        stage_v    = '0;
        stage_addr = '0;
        stage_rdy  = '0;
        for (int s = 0; s < DEPTH; s++) begin
            stage_v[s]              = stage_q[s].v;
            stage_addr[s*AW +: AW]  = stage_q[s].addr[AW-1:0];
            stage_rdy[s]            = ((s + 1) >= int'(stage_q[s].lat));
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_port_sel #(
            .DW    (DW),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_sel (
            .rd_en      (id_rd_en[i]),
            .rd_addr    (id_rd_addr[i*AW +: AW]),
            .rd_data    (id_rd_data[i*DW +: DW]),
            .stage_v    (stage_v),
            .stage_addr (stage_addr),
            .stage_rdy  (stage_rdy),
            .stage_data (stage_data),
            .fwd_data   (fwd_data[i*DW +: DW]),
            .fwd_hit    (fwd_hit[i]),
            .stall_req  (port_stall[i])
        );
    end

    assign stall_o = id_valid && (|port_stall);

    // Latency 0 behaves as a single-cycle ALU result.
    assign wr_lat_eff = (id_wr_lat == '0) ? LW'(LAT_ALU) : id_wr_lat;

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s];
        end
        if (flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_d[s].v = 1'b0;
            end
        end else begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                stage_d[s] = stage_q[s-1];
            end
            if (stall_o) begin
                stage_d[0] = '0;
            end else begin
                stage_d[0].v    = id_valid && id_wr_en;
                stage_d[0].addr = AW_DEF'(id_wr_addr);
                stage_d[0].lat  = LW_DEF'(wr_lat_eff);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Saturating; only reset clears it, flush leaves it alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (DEPTH=3, NUM_RD=3).
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NUM_RD = 3;
    localparam int DEPTH = 3;
    localparam int LW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid;
    logic [NUM_RD-1:0]    id_rd_en;
    logic [NUM_RD*AW-1:0] id_rd_addr;
    logic [NUM_RD*DW-1:0] id_rd_data;
    logic                 id_wr_en;
    logic [AW-1:0]        id_wr_addr;
    logic [LW-1:0]        id_wr_lat;
    logic [DEPTH*DW-1:0]  stage_data;
    logic                 flush;
    logic                 stall_o;
    logic [NUM_RD*DW-1:0] fwd_data;
    logic [NUM_RD-1:0]    fwd_hit;
`ifdef FWD_STALL_STATS_EN
    logic [31:0]          stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [NUM_RD*DW-1:0] RF_DATA = {32'hA2, 32'hA1, 32'hA0};
    localparam logic [DEPTH*DW-1:0]  SD_STD  = {32'h33, 32'hABCD, 32'h11};
    localparam logic [DEPTH*DW-1:0]  SD_WAW  = {32'h33, 32'h2, 32'h1};

    fwd_scoreboard #(
        .DW(DW), .AW(AW), .NUM_RD(NUM_RD), .DEPTH(DEPTH), .LW(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rd_en   (id_rd_en),
        .id_rd_addr (id_rd_addr),
        .id_rd_data (id_rd_data),
        .id_wr_en   (id_wr_en),
        .id_wr_addr (id_wr_addr),
        .id_wr_lat  (id_wr_lat),
        .stage_data (stage_data),
        .flush      (flush),
        .stall_o    (stall_o),
        .fwd_data   (fwd_data),
`ifdef FWD_STALL_STATS_EN
        .fwd_hit    (fwd_hit),
        .stall_cnt  (stall_cnt)
`else
        .fwd_hit    (fwd_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && id_valid && id_wr_en) begin
            assert (int'(id_wr_lat) <= DEPTH)
            else begin
                errors++;
                $error("FAIL lat_range: observed %0d, expected <= %0d", id_wr_lat, DEPTH);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rd_en   = '0;
        id_wr_en   = 1'b0;
        id_wr_addr = '0;
        id_wr_lat  = '0;
        flush      = 1'b0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        id_rd_en[p]          = 1'b1;
        id_rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input logic [AW-1:0] a, input int lat);
        id_valid   = 1'b1;
        id_wr_en   = 1'b1;
        id_wr_addr = a;
        id_wr_lat  = LW'(lat);
    endtask

    function automatic logic [DW-1:0] port(input int p);
        return fwd_data[p*DW +: DW];
    endfunction

    initial begin
        rst        = 1'b0;
        idle();
        id_rd_addr = '0;
        id_rd_data = RF_DATA;
        stage_data = SD_STD;
        rd(0, 5'd3);
        #1;
        check("reset_stall", stall_o, 1'b0);
        check("reset_hit", fwd_hit, 3'b000);
        check("reset_data", fwd_data, RF_DATA);
        repeat (2) tick();
        rst = 1'b1;
`ifdef FWD_STALL_STATS_EN
        check("cnt_after_reset", stall_cnt, 32'd0);
`endif

        // ALU chain: r3 lat 1 followed through every stage then retirement
        idle();
        wr(5'd3, LAT_ALU);
        tick();
        id_wr_en = 1'b0;
        rd(0, 5'd3);
        #1;
        check("alu_hit", fwd_hit, 3'b001);
        check("alu_data_s1", port(0), 32'h11);
        check("alu_stall", stall_o, 1'b0);
        check("alu_full_bus", fwd_data, {32'hA2, 32'hA1, 32'h11});
        tick();
        check("alu_data_s2", port(0), 32'hABCD);
        tick();
        check("alu_data_s3", port(0), 32'h33);
        tick();
        check("retire_hit", fwd_hit, 3'b000);
        check("retire_data", port(0), 32'hA0);
        check("retire_stall", stall_o, 1'b0);

        // Load-use: exactly one stall cycle, then stage 2 forward
        idle();
        wr(5'd5, LAT_LOAD);
        tick();
        wr(5'd9, LAT_ALU);
        rd(1, 5'd5);
        #1;
        check("lu_stall", stall_o, 1'b1);
        check("lu_hit_stalled", fwd_hit, 3'b000);
        check("lu_data_stalled", port(1), 32'hA1);
        tick();
        check("lu_stall_released", stall_o, 1'b0);
        check("lu_hit", fwd_hit, 3'b010);
        check("lu_data", port(1), 32'hABCD);
`ifdef FWD_STALL_STATS_EN
        check("cnt_after_lu", stall_cnt, 32'd1);
`endif
        tick();
        id_wr_en = 1'b0;
        rd(0, 5'd9);
        #1;
        check("lu_two_ports_hit", fwd_hit, 3'b011);
        check("lu_two_ports_data", fwd_data, {32'hA2, 32'h33, 32'h11});
        flush = 1'b1;
        tick();

        // WAW: two r7 producers, youngest wins; then a not-ready youngest
        idle();
        stage_data = SD_WAW;
        wr(5'd7, LAT_ALU);
        tick();
        tick();
        id_wr_en = 1'b0;
        rd(2, 5'd7);
        #1;
        check("waw_data", port(2), 32'h1);
        check("waw_hit", fwd_hit, 3'b100);
        check("waw_stall", stall_o, 1'b0);
        wr(5'd7, LAT_LOAD);
        tick();
        id_wr_en = 1'b0;
        #1;
        check("waw_young_not_ready_stall", stall_o, 1'b1);
        check("waw_young_not_ready_hit", fwd_hit, 3'b000);
        check("waw_young_not_ready_data", port(2), 32'hA2);
        id_valid = 1'b0;
        #1;
        check("stall_needs_id_valid", stall_o, 1'b0);
        tick();
        flush = 1'b1;
        tick();

        // Register 0 forwards normally; latency 0 acts as latency 1
        idle();
        stage_data = SD_STD;
        wr(5'd0, 0);
        tick();
        id_wr_en = 1'b0;
        rd(0, 5'd0);
        #1;
        check("r0_hit", fwd_hit, 3'b001);
        check("r0_data", port(0), 32'h11);
        check("r0_stall", stall_o, 1'b0);

        // Flush while stalled
        idle();
        wr(5'd5, LAT_LOAD);
        tick();
        id_wr_en = 1'b0;
        rd(1, 5'd5);
        #1;
        check("flush_pre_stall", stall_o, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_stall", stall_o, 1'b0);
        check("flush_hit", fwd_hit, 3'b000);
        check("flush_data", port(1), 32'hA1);
`ifdef FWD_STALL_STATS_EN
        check("cnt_after_flush", stall_cnt, 32'd2);
`endif

        // Asynchronous reset in the middle of a stall
        idle();
        wr(5'd5, LAT_LOAD);
        tick();
        id_wr_en = 1'b0;
        rd(1, 5'd5);
        #1;
        check("rst_pre_stall", stall_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_stall", stall_o, 1'b0);
        check("rst_mid_hit", fwd_hit, 3'b000);
        check("rst_mid_data", port(1), 32'hA1);
`ifdef FWD_STALL_STATS_EN
        check("cnt_after_rst", stall_cnt, 32'd0);
`endif
        tick();
        rst = 1'b1;
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
